stepper_motion_ctrl: RTL and testbench

STEPPER_MOTION_CTRL -- requirements
Module: stepper_motion_ctrl

---
 rtl/stepper_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_stepper_motion_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_motion_ctrl.sv
// Step/direction motion controller: relative moves with travel limits, abort, optional homing.
// Define STEPPER_HOMING_EN to build the HOME state (home_req / limit_lo inputs).
module stepper_motion_ctrl #(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned POS_W   = 16,
    parameter int unsigned MAX_POS = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_fwd,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic             abort,
    input  logic             home_req,
    input  logic             limit_lo,
    output logic [1:0]       drv_dir,
    output logic             drv_en,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);
    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);

`ifdef STEPPER_HOMING_EN
    typedef enum logic [1:0] {StIdle, StMove, StHome} state_t;
`else
    typedef enum logic [0:0] {StIdle, StMove} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic             r_fwd, w_fwd_nxt;
    logic [POS_W-1:0] r_count, w_count_nxt;
    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic [POS_W-1:0] r_pos, w_pos_nxt;
    logic             r_abort_done, w_abort_done_nxt;
    logic             w_tick, w_step, w_finish, w_at_bound, w_home_go;

`ifdef STEPPER_HOMING_EN
    assign w_home_go = home_req;
`else
    logic w_unused;
    assign w_home_go = 1'b0;
    assign w_unused  = home_req | limit_lo;
`endif

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_at_bound = r_fwd ? (r_pos >= POS_MAX) : (r_pos == '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_fwd_nxt        = r_fwd;
        w_count_nxt      = r_count;
        w_presc_nxt      = r_presc;
        w_pos_nxt        = r_pos;
        w_abort_done_nxt = 1'b0;
        w_step           = 1'b0;
        w_finish         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_home_go) begin
`ifdef STEPPER_HOMING_EN
                    w_state_nxt = StHome;
`endif
                    w_presc_nxt = '0;
                end else if (cmd_valid) begin
                    w_state_nxt = StMove;
                    w_fwd_nxt   = cmd_fwd;
                    w_count_nxt = cmd_steps;
                    w_presc_nxt = '0;
                end
            end
            StMove: begin
                // Abort wins over a coincident tick: no pulse, no position change.
                if (abort) begin
                    w_state_nxt      = StIdle;
                    w_abort_done_nxt = 1'b1;
                end else if (r_count == '0 || w_at_bound) begin
                    w_finish    = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        w_step      = 1'b1;
                        w_pos_nxt   = r_fwd ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                        w_count_nxt = r_count - POS_W'(1);
                    end
                end
            end
`ifdef STEPPER_HOMING_EN
            StHome: begin
                if (abort) begin
                    w_state_nxt      = StIdle;
                    w_abort_done_nxt = 1'b1;
                end else if (limit_lo) begin
                    w_finish    = 1'b1;
                    w_pos_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        w_step = 1'b1;
                        // Keep pulsing toward the switch but never let position go negative.
                        if (r_pos != '0) begin
                            w_pos_nxt = r_pos - POS_W'(1);
                        end
                    end
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_fwd        <= 1'b0;
            r_count      <= '0;
            r_presc      <= '0;
            r_pos        <= '0;
            r_abort_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fwd        <= w_fwd_nxt;
            r_count      <= w_count_nxt;
            r_presc      <= w_presc_nxt;
            r_pos        <= w_pos_nxt;
            r_abort_done <= w_abort_done_nxt;
        end
    end

    always_comb begin
        drv_dir = 2'b00;
        if (r_state == StMove) begin
            drv_dir = r_fwd ? 2'b10 : 2'b01;
        end
`ifdef STEPPER_HOMING_EN
        if (r_state == StHome) begin
            drv_dir = 2'b01;
        end
`endif
    end

    assign cmd_ready = (r_state == StIdle) && !rst;
    assign busy      = (r_state != StIdle);
    assign drv_en    = w_step;
    assign done      = w_finish | r_abort_done;
    assign position  = r_pos;

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Self-checking bench for stepper_motion_ctrl (CLK_DIV=4, MAX_POS=10); vector table plus
// hand-written abort, reset and homing sequences. Homing checks build with STEPPER_HOMING_EN.
module tb_stepper_motion_ctrl;
    localparam int CDIV = 4;
    localparam int PW   = 16;
    localparam int MAXP = 10;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_fwd = 1'b0;
    logic [PW-1:0] cmd_steps = '0;
    logic          abort = 1'b0;
    logic          home_req = 1'b0;
    logic          limit_lo = 1'b0;
    logic [1:0]    drv_dir;
    logic          drv_en;
    logic          busy;
    logic          done;
    logic [PW-1:0] position;

    stepper_motion_ctrl #(.CLK_DIV(CDIV), .POS_W(PW), .MAX_POS(MAXP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fwd(cmd_fwd), .cmd_steps(cmd_steps), .abort(abort), .home_req(home_req),
        .limit_lo(limit_lo), .drv_dir(drv_dir), .drv_en(drv_en), .busy(busy), .done(done),
        .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fwd;
        int   steps;
        int   exp_k;
        int   exp_pos;
    } vec_t;

    typedef struct {
        int         pulses;
        int         pos;
        int         done_t;
        logic [1:0] dir;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one move and follow it to its done pulse; expected k pulses at T+4i, done at T+4k+1.
    task automatic do_move(input logic fwd, input int steps, input int exp_k, input int exp_pos);
        exp_t e;
        exp_t got_e;
        int   pulses = 0;
        int   pat_err = 0;
        int   dir_err = 0;
        int   got_t = -1;
        e.pulses = exp_k;
        e.pos    = exp_pos;
        e.done_t = CDIV * exp_k + 1;
        e.dir    = fwd ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("ready_before_move", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_fwd   = fwd;
        cmd_steps = PW'(steps);
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int t = 1; t <= TMO; t++) begin
            @(negedge clk);
            if (drv_en === 1'b1) pulses++;
            if (drv_en !== ((t % CDIV == 0) && (t / CDIV <= exp_k))) pat_err++;
            if (drv_dir !== e.dir) dir_err++;
            if (done === 1'b1) begin
                got_t = t;
                break;
            end
        end
        got_e = sb.pop_front();
        chk("done_time", got_t, got_e.done_t);
        chk("pulse_count", pulses, got_e.pulses);
        chk("pulse_pattern_errs", pat_err, 0);
        chk("dir_during_move_errs", dir_err, 0);
        @(negedge clk);
        chk("pos_after_move", position, got_e.pos);
        chk("ready_after_move", cmd_ready, 1);
        chk("dir_idle", drv_dir, 2'b00);
        chk("done_single", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        vecs[0] = '{1'b1, 3, 3, 3};
        vecs[1] = '{1'b0, 5, 3, 0};
        vecs[2] = '{1'b1, 0, 0, 0};
        vecs[3] = '{1'b0, 2, 0, 0};
        vecs[4] = '{1'b1, 12, 10, 10};
        vecs[5] = '{1'b1, 1, 0, 10};
        vecs[6] = '{1'b0, 4, 4, 6};
        vecs[7] = '{1'b1, 2, 2, 8};
        vecs[8] = '{1'b0, 8, 8, 0};

        #2;
        chk("rst_position", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drv_en", drv_en, 0);
        chk("rst_drv_dir", drv_dir, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 9; i++) begin
            do_move(vecs[i].fwd, vecs[i].steps, vecs[i].exp_k, vecs[i].exp_pos);
        end

        // Abort on the cycle of the 2nd pulse of a 6-step forward move.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_fwd = 1'b1; cmd_steps = PW'(6);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_suppress_en", drv_en, 0);
        chk("abort_pos_hold", position, 1);
        chk("abort_no_early_done", done, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_done", done, 1);
        chk("abort_dir_idle", drv_dir, 2'b00);
        chk("abort_pos", position, 1);
        chk("abort_ready", cmd_ready, 1);
        @(negedge clk);
        chk("abort_done_single", done, 0);

        // Reset in the middle of a move.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_fwd = 1'b1; cmd_steps = PW'(5);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        chk("premid_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_position", position, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_drv_en", drv_en, 0);
        chk("midrst_drv_dir", drv_dir, 0);
        chk("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done !== 1'b0 || drv_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("post_rst_quiet_errs", bad, 0);
        chk("post_rst_ready", cmd_ready, 1);

`ifdef STEPPER_HOMING_EN
        do_move(1'b1, 7, 7, 7);
        // home_req and cmd_valid together: homing wins.
        @(negedge clk);
        home_req = 1'b1; cmd_valid = 1'b1; cmd_fwd = 1'b1; cmd_steps = PW'(1);
        @(posedge clk);
        #1 home_req = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("home_dir", drv_dir, 2'b01);
        chk("home_busy", busy, 1);
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (drv_en === 1'b1) bad++;
            if (bad == 4) break;
        end
        chk("home_pulses", bad, 4);
        @(posedge clk);
        #1 limit_lo = 1'b1;
        @(negedge clk);
        chk("home_limit_done", done, 1);
        chk("home_limit_no_en", drv_en, 0);
        chk("home_pos_before_zero", position, 3);
        @(posedge clk);
        #1 limit_lo = 1'b0;
        @(negedge clk);
        chk("home_pos_zero", position, 0);
        chk("home_ready", cmd_ready, 1);
        chk("home_done_single", done, 0);

        // Switch already closed on entry: finish at once with no pulse.
        do_move(1'b1, 2, 2, 2);
        @(negedge clk);
        limit_lo = 1'b1; home_req = 1'b1;
        @(posedge clk);
        #1 home_req = 1'b0;
        @(negedge clk);
        chk("home_closed_done", done, 1);
        chk("home_closed_no_en", drv_en, 0);
        @(posedge clk);
        #1 limit_lo = 1'b0;
        @(negedge clk);
        chk("home_closed_pos", position, 0);
        chk("home_closed_ready", cmd_ready, 1);
`else
        // Without homing, home_req and limit_lo have no effect on a normal move.
        home_req = 1'b1;
        limit_lo = 1'b1;
        do_move(1'b1, 2, 2, 2);
        home_req = 1'b0;
        limit_lo = 1'b0;
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
